// File: rtl/adam_cfg_pkg.sv
// Build-time SoC configuration record and its default value.
package adam_cfg_pkg;

    typedef struct packed {
        int NO_GPIOS;
        int NO_SPIS;
        int NO_TIMERS;
        int NO_UARTS;
    } LSP_T;

    typedef struct packed {
        int          ADDR_WIDTH;
        int          DATA_WIDTH;
        int          GPIO_WIDTH;
        logic [31:0] RST_BOOT_ADDR;
        int          NO_CPUS;
        int          NO_DMAS;
        int          NO_MEMS;
        logic        EN_LPCPU;
        logic        EN_LPMEM;
        logic        EN_DEBUG;
        LSP_T        LSPA;
        LSP_T        LSPB;
        logic        BOOTSTRAP_CPU0;
        logic        BOOTSTRAP_MEM0;
        logic        BOOTSTRAP_LPCPU;
        logic        BOOTSTRAP_LPMEM;
    } CFG_T;

    localparam CFG_T CFG = '{
        ADDR_WIDTH:      32,
        DATA_WIDTH:      32,
        GPIO_WIDTH:      16,
        RST_BOOT_ADDR:   32'h0000_0000,
        NO_CPUS:         1,
        NO_DMAS:         1,
        NO_MEMS:         3,
        EN_LPCPU:        1'b1,
        EN_LPMEM:        1'b1,
        EN_DEBUG:        1'b1,
        LSPA:            '{NO_GPIOS: 1, NO_SPIS: 1, NO_TIMERS: 1, NO_UARTS: 1},
        LSPB:            '{NO_GPIOS: 1, NO_SPIS: 1, NO_TIMERS: 1, NO_UARTS: 1},
        BOOTSTRAP_CPU0:  1'b1,
        BOOTSTRAP_MEM0:  1'b1,
        BOOTSTRAP_LPCPU: 1'b0,
        BOOTSTRAP_LPMEM: 1'b0
    };

endpackage

// File: rtl/adam_sysinfo_if.sv
// APB3 bus bundle for the sysinfo responder.
interface adam_sysinfo_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/adam_sysinfo.sv
// Read-only view of the SoC configuration, a scratch register and a 64-bit
// cycle counter whose HI half is read through a shadow latched on LO reads.
module adam_sysinfo
    import adam_cfg_pkg::*;
#(
    parameter CFG_T        CFG = adam_cfg_pkg::CFG,
    parameter logic [31:0] ID  = 32'hADA0_0001
) (
    input logic           clk,
    input logic           rst,
    adam_sysinfo_if.slave apb
);

    localparam logic [3:0] W_ID      = 4'h0;
    localparam logic [3:0] W_WIDTHS  = 4'h1;
    localparam logic [3:0] W_BOOT    = 4'h2;
    localparam logic [3:0] W_CORES   = 4'h3;
    localparam logic [3:0] W_LSPA    = 4'h4;
    localparam logic [3:0] W_LSPB    = 4'h5;
    localparam logic [3:0] W_BSTRAP  = 4'h6;
    localparam logic [3:0] W_SCRATCH = 4'h7;
    localparam logic [3:0] W_CYC_LO  = 4'h8;
    localparam logic [3:0] W_CYC_HI  = 4'h9;
    localparam logic [3:0] W_CTRL    = 4'hA;

    function automatic logic [31:0] lsp_word(input LSP_T l);
        return {16'h0, 4'(l.NO_UARTS), 4'(l.NO_TIMERS), 4'(l.NO_SPIS), 4'(l.NO_GPIOS)};
    endfunction

    logic [31:0] scratch_q;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q;
    logic [31:0] hi_pend_q;
    logic        lo_rd_q;
    logic        en_q;
    logic        pready_q;
    logic [31:0] prdata_q;
    logic        pslverr_q;

    logic [3:0]  word;
    logic [31:0] rd_data_d;
    logic        in_range_d;
    logic        writable_d;
    logic        err_d;
    logic        commit;
    logic        wr_ok;
    logic        clr_hit;
    logic        unused_bits;

    assign word = apb.paddr[5:2];

    always_comb begin
        rd_data_d  = 32'h0;
        in_range_d = 1'b1;
        writable_d = 1'b0;
        case (word)
            W_ID:      rd_data_d = ID;
            W_WIDTHS:  rd_data_d = {8'h0, 8'(CFG.GPIO_WIDTH), 8'(CFG.DATA_WIDTH),
                                    8'(CFG.ADDR_WIDTH)};
            W_BOOT:    rd_data_d = CFG.RST_BOOT_ADDR;
            W_CORES:   rd_data_d = {13'h0, CFG.EN_DEBUG, CFG.EN_LPMEM, CFG.EN_LPCPU,
                                    4'h0, 4'(CFG.NO_MEMS), 4'(CFG.NO_DMAS),
                                    4'(CFG.NO_CPUS)};
            W_LSPA:    rd_data_d = lsp_word(CFG.LSPA);
            W_LSPB:    rd_data_d = lsp_word(CFG.LSPB);
            W_BSTRAP:  rd_data_d = {28'h0, CFG.BOOTSTRAP_LPMEM, CFG.BOOTSTRAP_LPCPU,
                                    CFG.BOOTSTRAP_MEM0, CFG.BOOTSTRAP_CPU0};
            W_SCRATCH: begin
                rd_data_d  = scratch_q;
                writable_d = 1'b1;
            end
            W_CYC_LO:  rd_data_d = cnt_q[31:0];
            W_CYC_HI:  rd_data_d = shadow_q;
            W_CTRL: begin
                rd_data_d  = {31'h0, en_q};
                writable_d = 1'b1;
            end
            default:   in_range_d = 1'b0;
        endcase
    end

    assign err_d = !in_range_d || (apb.paddr[1:0] != 2'b00) || (apb.pwrite && !writable_d);

    // The error decision is taken in the setup phase; APB holds address and
    // data stable through the access phase, so commit reuses the live bus.
    assign commit  = apb.psel && apb.penable && pready_q;
    assign wr_ok   = commit && apb.pwrite && !pslverr_q;
    assign clr_hit = wr_ok && (word == W_CTRL) && apb.pstrb[0] && apb.pwdata[1];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_hit) begin
            cnt_d = 64'h0;
        end else if (en_q) begin
            cnt_d = cnt_q + 64'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q <= 32'h0;
            cnt_q     <= 64'h0;
            shadow_q  <= 32'h0;
            hi_pend_q <= 32'h0;
            lo_rd_q   <= 1'b0;
            en_q      <= 1'b1;
            pready_q  <= 1'b0;
            prdata_q  <= 32'h0;
            pslverr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (apb.psel && !apb.penable) begin
                pready_q  <= 1'b1;
                pslverr_q <= err_d;
                prdata_q  <= (err_d || apb.pwrite) ? 32'h0 : rd_data_d;
                // HI is held pending so an abandoned LO read leaves the shadow alone.
                lo_rd_q   <= !err_d && !apb.pwrite && (word == W_CYC_LO);
                hi_pend_q <= cnt_q[63:32];
            end else begin
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
                prdata_q  <= 32'h0;
                lo_rd_q   <= 1'b0;
                if (commit && lo_rd_q) begin
                    shadow_q <= hi_pend_q;
                end
                if (wr_ok && (word == W_SCRATCH)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (apb.pstrb[i]) begin
                            scratch_q[8*i +: 8] <= apb.pwdata[8*i +: 8];
                        end
                    end
                end
                if (wr_ok && (word == W_CTRL) && apb.pstrb[0]) begin
                    en_q <= apb.pwdata[0];
                end
            end
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;

    assign unused_bits = ^{apb.pprot, apb.paddr};

endmodule

// File: tb/tb_adam_sysinfo.sv
// Directed scoreboard bench for adam_sysinfo.
module tb_adam_sysinfo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adam_sysinfo_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

    adam_sysinfo dut (
        .clk (clk),
        .rst (rst),
        .apb (apb)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        logic        is_rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input string tag,
                        input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        sb.push_back('{tag, exp_data, exp_err, !wr});
        @(negedge clk);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = wdata;
        apb.pstrb   = strb;
        check({tag, ".rdy_setup"}, 32'(apb.pready), 32'h0);
        @(negedge clk);
        apb.penable = 1'b1;
        e = sb.pop_front();
        check({e.tag, ".rdy"}, 32'(apb.pready), 32'h1);
        check({e.tag, ".err"}, 32'(apb.pslverr), 32'(e.err));
        if (e.is_rd) check({e.tag, ".data"}, apb.prdata, e.data);
    endtask

    task automatic rd(input logic [31:0] addr, input string tag,
                      input logic [31:0] exp_data, input logic exp_err);
        xfer(1'b0, addr, 32'h0, 4'h0, tag, exp_data, exp_err);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input string tag, input logic exp_err);
        xfer(1'b1, addr, data, strb, tag, 32'h0, exp_err);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        check({tag, ".rdy_idle"}, 32'(apb.pready), 32'h0);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, ".pready"},  32'(apb.pready),  32'h0);
        check({tag, ".prdata"},  apb.prdata,       32'h0);
        check({tag, ".pslverr"}, 32'(apb.pslverr), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = 32'h0;
        apb.pwdata  = 32'h0;
        apb.pstrb   = 4'h0;
        apb.pprot   = 3'h0;

        repeat (3) @(negedge clk);
        check_outs_zero("reset");
        rst = 1'b0;

        rd(32'h00, "id",        32'hADA0_0001, 1'b0);
        rd(32'h04, "widths",    32'h0010_2020, 1'b0);
        rd(32'h08, "boot",      32'h0000_0000, 1'b0);
        rd(32'h0C, "cores",     32'h0007_0311, 1'b0);
        rd(32'h10, "lspa",      32'h0000_1111, 1'b0);
        rd(32'h14, "lspb",      32'h0000_1111, 1'b0);
        rd(32'h18, "bootstrap", 32'h0000_0003, 1'b0);
        idle("after_ro");

        wr(32'h1C, 32'hDEAD_BEEF, 4'b0101, "scratch_wr", 1'b0);
        idle("scratch_gap");
        rd(32'h1C, "scratch_strb", 32'h00AD_00EF, 1'b0);
        wr(32'h04, 32'hFFFF_FFFF, 4'hF, "wr_ro", 1'b1);
        rd(32'h04, "widths_kept", 32'h0010_2020, 1'b0);
        wr(32'h20, 32'h1234_5678, 4'hF, "wr_cyc_lo", 1'b1);
        rd(32'h30, "rd_oob30", 32'h0, 1'b1);
        rd(32'h2C, "rd_oob2c", 32'h0, 1'b1);
        rd(32'h1D, "rd_misalign", 32'h0, 1'b1);
        wr(32'h1E, 32'h0, 4'hF, "wr_misalign", 1'b1);
        rd(32'h1C, "scratch_kept", 32'h00AD_00EF, 1'b0);

        wr(32'h1C, 32'hCAFE_F00D, 4'hF, "b2b_wr", 1'b0);
        rd(32'h1C, "b2b_rd", 32'hCAFE_F00D, 1'b0);

        wr(32'h28, 32'h2, 4'h1, "ctrl_clr", 1'b0);
        wr(32'h28, 32'h0, 4'h1, "ctrl_off", 1'b0);
        rd(32'h28, "ctrl_off_rd", 32'h0, 1'b0);
        idle("pre_force");
        @(negedge clk);
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
        @(negedge clk);
        release dut.cnt_q;
        wr(32'h28, 32'h1, 4'h1, "ctrl_en", 1'b0);
        idle("carry_gap");
        rd(32'h20, "carry_lo",  32'hFFFF_FFFF, 1'b0);
        rd(32'h24, "carry_hi",  32'h0, 1'b0);
        rd(32'h24, "carry_hi2", 32'h0, 1'b0);
        rd(32'h20, "post_lo",   32'h5, 1'b0);
        rd(32'h24, "post_hi",   32'h1, 1'b0);

        wr(32'h28, 32'h3, 4'h1, "ctrl_clr_en", 1'b0);
        rd(32'h20, "clr_lo",    32'h0, 1'b0);
        rd(32'h24, "clr_hi",    32'h0, 1'b0);
        rd(32'h20, "resume_lo", 32'h4, 1'b0);
        rd(32'h28, "ctrl_rd",   32'h1, 1'b0);
        idle("pre_rst");

        @(negedge clk);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = 32'h1C;
        apb.pwdata  = 32'h1234_5678;
        apb.pstrb   = 4'hF;
        @(negedge clk);
        apb.penable = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_outs_zero("in_rst1");
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        @(negedge clk);
        check_outs_zero("in_rst2");
        rst = 1'b0;
        rd(32'h20, "rst_first_inc", 32'h1, 1'b0);
        rd(32'h1C, "rst_scratch",   32'h0, 1'b0);
        rd(32'h28, "rst_ctrl",      32'h1, 1'b0);
        idle("end");

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adam_sysinfo.md
# adam_sysinfo

APB3 responder that exposes the build-time SoC configuration (`adam_cfg_pkg::CFG_T`) to software as read-only registers, alongside a scratch register and a 64-bit free-running cycle counter with coherent snapshot reads. It consumes the configuration record and makes it visible at run time, so boot code and drivers can discover CPU, memory and peripheral counts and the boot address. It sits on the system peripheral APB segment.

## Interface
- `CFG`, default `adam_cfg_pkg::CFG`: configuration record reflected in the registers. `CFG.ADDR_WIDTH` and `CFG.DATA_WIDTH` (32) size the bus.
- `ID`, default `32'hADA0_0001`: value returned at offset 0x00.
- `clk` in 1: clock. One clock only.
- `rst` in 1: reset, synchronous, active-high.
- `paddr` in ADDR_WIDTH: byte address. Only `paddr[5:0]` is decoded.
- `pprot` in 3: ignored.
- `psel` in 1: select.
- `penable` in 1: access phase.
- `pwrite` in 1: write when high.
- `pwdata` in DATA_WIDTH: write data.
- `pstrb` in DATA_WIDTH/8: byte strobes.
- `pready` out 1: transfer complete.
- `prdata` out DATA_WIDTH: read data.
- `pslverr` out 1: error response.

## Operation
Register map (word offsets; all fields not listed read 0):
- 0x00 ID (RO): `ID`.
- 0x04 WIDTHS (RO): [7:0] ADDR_WIDTH, [15:8] DATA_WIDTH, [23:16] GPIO_WIDTH.
- 0x08 BOOT (RO): RST_BOOT_ADDR.
- 0x0C CORES (RO): [3:0] NO_CPUS, [7:4] NO_DMAS, [11:8] NO_MEMS, [16] EN_LPCPU, [17] EN_LPMEM, [18] EN_DEBUG.
- 0x10 LSPA (RO) and 0x14 LSPB (RO): [3:0] GPIOS, [7:4] SPIS, [11:8] TIMERS, [15:12] UARTS.
- 0x18 BOOTSTRAP (RO): [0] CPU0, [1] MEM0, [2] LPCPU, [3] LPMEM.
- 0x1C SCRATCH (RW): byte-granular per `pstrb`. Reset value 0.
- 0x20 CYCLE_LO (RO): returns counter[31:0]. In the same cycle, counter[63:32] is latched into the HI shadow.
- 0x24 CYCLE_HI (RO): returns the HI shadow, not the live counter. Shadow reset value 0.
- 0x28 CTRL (RW, only byte 0 honoured):
  - [0] EN, reset value 1.
  - [1] CLR, write-1 pulse; always reads 0.

Counter behaviour:
- 64-bit; increments by 1 every cycle while EN=1.
- Wraps from 2^64-1 to 0.
- CLR clears it to 0 on the commit cycle. Clear wins over a simultaneous increment.

Error rules. `pslverr`=1 and no state change for any of:
- a write to an RO offset;
- an offset ≥ 0x2C;
- `paddr[1:0]` ≠ 0.

Erroneous reads return `prdata`=0 and do not update the HI shadow.

Field values wider than their slot are truncated to the slot width. No saturation.

## Timing
- Bus phases:
  - Setup phase: `psel`=1, `penable`=0.
  - Access phase: `psel`=1, `penable`=1.
- Zero wait states. `pready`, `prdata` and `pslverr` are registered in the setup-phase cycle and are valid throughout the access phase.
- Outside an access phase: `pready`=0, `prdata`=0, `pslverr`=0.
- Write commit:
  - Writes to SCRATCH and CTRL take effect on the clock edge that ends the access phase (`psel & penable & pready`).
  - A read issued immediately after a write returns the new value.
- Counter sampling: the value returned for CYCLE_LO, and the HI shadow latch, are both taken from the counter as it stands in the setup-phase cycle.
- Back-to-back transfers (a setup phase directly after an access phase) are supported with no idle cycle.
- `psel` dropping without an access phase: the setup-registered response is discarded and no state changes.
- Reset:
  - Every output goes to 0.
  - SCRATCH = 0, counter = 0, shadow = 0, EN = 1.
  - An in-flight transfer is abandoned and its write is not committed.
- Counter after reset: the first increment occurs on the first clock after `rst` deasserts.

## Test plan
- Reset release, then read 0x00 through 0x18 with the default config → ID=0xADA00001, WIDTHS=0x00102020, BOOT=0, CORES=0x00070311, LSPA=LSPB=0x1111, BOOTSTRAP=0x3. `pready` is high for exactly one access cycle each time; `pslverr`=0.
- Write 0x1C with 0xDEADBEEF and pstrb=4'b0101, then read it back → 0x00AD00EF. Next, write 0x04 → `pslverr`=1 and WIDTHS unchanged. Then read 0x30 → `pslverr`=1, `prdata`=0.
- Coherent 64-bit read across a carry:
  - Setup: write CTRL=0x2, then write CTRL=0; force the counter to 0x00000000_FFFFFFFE through a back-door or by holding it.
  - Set EN=1, read 0x20, then read 0x24 → the LO/HI pair forms a single consistent 64-bit value.
  - A second HI read with no intervening LO read returns the same shadow value.
- CLR and EN in one write: write CTRL=0x3 while counting → counter reads 0 (clear beats increment) and counting resumes; CTRL reads 0x1.
- Reset asserted during the access phase of a write of 0x12345678 to SCRATCH → SCRATCH reads 0 after reset, and all outputs are 0 while `rst`=1.
- Back-to-back write/read to 0x1C with no idle cycle → the read returns the value just written.
